// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing generator.
//   - vga_state_e   : control state of the timing generator
//   - DEF_*         : default 640x480@60 Hz timing (25 MHz pixel clock)
//   - timing_total  : sums the four segments of one timing axis
//   - CNT_W/CNT_MAX : width and largest value of the h/v position counters
package vga_timing_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } vga_state_e;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = 1023;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_FP        = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BP        = 48;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_V_FP        = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BP        = 33;
    localparam int unsigned DEF_LOCK_SETTLE = 16;

    // Total period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL =
        timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_lock_monitor.sv
// PLL lock qualification.
//   clk        : pixel clock
//   rst        : synchronous active-high reset
//   pll_locked : raw PLL lock flag, asynchronous to clk
//   settle_clr : holds the settle counter at zero (controller is waiting for lock)
//   lock_s     : pll_locked after a 2-flop synchronizer
//   lock_ok    : lock_s has been high for LOCK_SETTLE consecutive settle cycles
module vga_lock_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic settle_clr,
    output logic lock_s,
    output logic lock_ok
);

    localparam int unsigned SW = (LOCK_SETTLE > 2) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [SW-1:0] settle_cnt_r;

    // Two-stage synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            sync2_r <= sync1_r;
        end
    end

    // Settle counter: restarts on any lock drop, saturates at its last value
    // so lock_ok stays asserted while lock is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_r <= '0;
        end else if (settle_clr || !sync2_r) begin
            settle_cnt_r <= '0;
        end else if (settle_cnt_r != SETTLE_LAST) begin
            settle_cnt_r <= settle_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    assign lock_s  = sync2_r;
    assign lock_ok = sync2_r && (settle_cnt_r == SETTLE_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA timing generator (defaults), clocked by the 25 MHz pixel
// clock. All outputs stay at blanking levels until the PLL lock has been
// stable for LOCK_SETTLE cycles, and return to blanking on lock loss.
//   clk         : pixel clock
//   rst         : synchronous active-high reset
//   pll_locked  : PLL lock flag (asynchronous)
//   hsync/vsync : sync pulses, active level SYNC_POL
//   de          : visible-region data enable
//   x, y        : pixel column/row while de, else 0
//   line_start  : pulse at the first clock of every line
//   frame_start : pulse at the first clock of every frame
//   running     : timing is being generated
// All outputs are registered and mutually aligned, one clock after the
// counter values they describe.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Counters are CNT_W bits wide; larger timings cannot be represented.
    if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_total_too_large
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    vga_state_e       state_r;
    vga_state_e       state_nx_s;
    logic             lock_s;
    logic             lock_ok_s;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;

    logic             de_s;
    logic             hs_act_s;
    logic             vs_act_s;
    logic             h_end_s;
    logic             v_end_s;

    logic             hsync_r;
    logic             vsync_r;
    logic             de_r;
    logic [CNT_W-1:0] x_r;
    logic [CNT_W-1:0] y_r;
    logic             line_start_r;
    logic             frame_start_r;
    logic             running_r;

    vga_lock_monitor #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_monitor (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .settle_clr (state_r == WAIT_LOCK),
        .lock_s     (lock_s),
        .lock_ok    (lock_ok_s)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_LOCK;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: any synchronized lock drop returns to WAIT_LOCK.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx_s = SETTLE;
                end else begin
                    state_nx_s = WAIT_LOCK;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_nx_s = WAIT_LOCK;
                end else if (lock_ok_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = SETTLE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx_s = WAIT_LOCK;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s = WAIT_LOCK;
            end
        endcase
    end

    assign h_end_s = (h_cnt_r == H_LAST);
    assign v_end_s = (v_cnt_r == V_LAST);

    // Pixel/line position counters; parked at the origin outside RUN so
    // every RUN entry starts a fresh frame.
    always_ff @(posedge clk) begin
        if (rst || (state_r != RUN)) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_end_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= v_end_s ? '0 : (v_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            h_cnt_r <= h_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            v_cnt_r <= v_cnt_r;
        end
    end

    // Combinational decode of the current position.
    always_comb begin
        de_s     = 1'b0;
        hs_act_s = 1'b0;
        vs_act_s = 1'b0;
        if ((h_cnt_r < H_VIS) && (v_cnt_r < V_VIS)) begin
            de_s = 1'b1;
        end else begin
            de_s = 1'b0;
        end
        if ((h_cnt_r >= HS_START) && (h_cnt_r < HS_END)) begin
            hs_act_s = 1'b1;
        end else begin
            hs_act_s = 1'b0;
        end
        if ((v_cnt_r >= VS_START) && (v_cnt_r < VS_END)) begin
            vs_act_s = 1'b1;
        end else begin
            vs_act_s = 1'b0;
        end
    end

    // Output register: decoded timing in RUN, blanking levels otherwise.
    always_ff @(posedge clk) begin
        if (rst || (state_r != RUN)) begin
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            de_r          <= 1'b0;
            x_r           <= '0;
            y_r           <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            hsync_r       <= hs_act_s ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= vs_act_s ? SYNC_POL : ~SYNC_POL;
            de_r          <= de_s;
            x_r           <= de_s ? h_cnt_r : '0;
            y_r           <= de_s ? v_cnt_r : '0;
            line_start_r  <= (h_cnt_r == '0);
            frame_start_r <= (h_cnt_r == '0) && (v_cnt_r == '0);
            running_r     <= 1'b1;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign x           = x_r;
    assign y           = y_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign running     = running_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen. Horizontal timing uses the 640-pixel
// defaults; the vertical axis is shortened (20 visible lines, 27 total) so a
// whole frame fits in a short run.
module tb_vga_timing_gen;

    localparam int H_TOT  = 800;
    localparam int V_ACT  = 20;
    localparam int V_FPP  = 2;
    localparam int V_SYN  = 2;
    localparam int V_BPP  = 3;
    localparam int V_TOT  = V_ACT + V_FPP + V_SYN + V_BPP;
    localparam int FRAME  = H_TOT * V_TOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       hsync, vsync, de, line_start, frame_start, running;
    logic [9:0] x, y;

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPP),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_hsync"}, int'(hsync), 1);
        check({tag, "_vsync"}, int'(vsync), 1);
        check({tag, "_de"}, int'(de), 0);
        check({tag, "_xy"}, int'({x, y}), 0);
        check({tag, "_strobes"}, int'({line_start, frame_start}), 0);
        check({tag, "_running"}, int'(running), 0);
    endtask

    // Counts falling edges until running rises (bounded).
    task automatic wait_running(output int n);
        n = 0;
        while (!running && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_frame_origin(input string tag);
        check({tag, "_fs"}, int'(frame_start), 1);
        check({tag, "_de"}, int'(de), 1);
        check({tag, "_xy"}, int'({x, y}), 0);
    endtask

    initial begin
        int n;
        int de_line0, hs_first, hs_cnt0, ls_cnt, ls_second;
        int vs_cnt, vs_first, de_lines, fs_cnt, xy_bad, run_bad;
        int hc, vc;
        logic       exp_de;
        logic [9:0] exp_x, exp_y;

        // Reset held for 3 cycles with the PLL already locked.
        rst = 1'b1;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        check_blank("reset");

        // Startup: 2 sync + 16 settle + state + output register.
        rst = 1'b0;
        wait_running(n);
        check_range("startup_latency", n, 18, 20);
        check_frame_origin("startup");

        // One full frame observed cycle by cycle from the first frame_start.
        de_line0 = 0; hs_first = -1; hs_cnt0 = 0; ls_cnt = 0; ls_second = -1;
        vs_cnt = 0; vs_first = -1; de_lines = 0; fs_cnt = 0; xy_bad = 0; run_bad = 0;
        for (int c = 0; c < FRAME; c++) begin
            hc = c % H_TOT;
            vc = c / H_TOT;
            exp_de = (hc < 640) && (vc < V_ACT);
            exp_x  = exp_de ? hc[9:0] : 10'd0;
            exp_y  = exp_de ? vc[9:0] : 10'd0;
            if ((de !== exp_de) || (x !== exp_x) || (y !== exp_y)) xy_bad++;
            if (c < H_TOT && de) de_line0++;
            if (c < H_TOT && !hsync) begin
                hs_cnt0++;
                if (hs_first < 0) hs_first = c;
            end
            if (line_start) begin
                ls_cnt++;
                if (c > 0 && ls_second < 0) ls_second = c;
                if (de) de_lines++;
            end
            if (!vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = c;
            end
            if (frame_start) fs_cnt++;
            if (!running) run_bad++;
            @(negedge clk);
        end
        check("line_de_width", de_line0, 640);
        check("hsync_start", hs_first, 656);
        check("hsync_width", hs_cnt0, 96);
        check("line_period", ls_second, 800);
        check("lines_per_frame", ls_cnt, V_TOT);
        check("vsync_width", vs_cnt, V_SYN * H_TOT);
        check("vsync_start", vs_first, (V_ACT + V_FPP) * H_TOT);
        check("de_lines", de_lines, V_ACT);
        check("frame_start_count", fs_cnt, 1);
        check("pixel_position_errors", xy_bad, 0);
        check("running_drops", run_bad, 0);
        check_frame_origin("frame_period");

        // Lock loss mid-line in RUN.
        repeat (300) @(negedge clk);
        check("pre_loss_x", int'(x), 300);
        pll_locked = 1'b0;
        n = 0;
        while ((de || running) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_range("loss_blank_latency", n, 1, 4);
        check_blank("after_loss");
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        wait_running(n);
        check_range("relock_latency", n, 18, 20);
        check_frame_origin("relock");

        // One-cycle lock glitch in the middle of SETTLE restarts the settle.
        pll_locked = 1'b0;
        repeat (8) @(negedge clk);
        check("wait_lock_running", int'(running), 0);
        pll_locked = 1'b1;
        repeat (10) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        check("glitch_running", int'(running), 0);
        wait_running(n);
        check_range("glitch_relock_latency", n, 18, 20);
        check_frame_origin("glitch_relock");

        // Reset mid-frame at x=300, y=10.
        n = 0;
        while (!(de && x == 10'd300 && y == 10'd10) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("reached_x300_y10", int'(de && x == 10'd300 && y == 10'd10), 1);
        rst = 1'b1;
        @(negedge clk);
        check_blank("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_running(n);
        check_range("post_reset_latency", n, 18, 20);
        check_frame_origin("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
